// File: rtl/gray_pkg.sv
// Shared widths and FSM encoding for the grayscale frame packer.
package gray_pkg;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gray_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed words {last, addr, data}.
// Handshake: a push is taken when not full, or when full with a pop in the same
// cycle; a pop is taken only when not empty; flush empties the FIFO at the edge.
module gray_word_fifo
    import gray_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 50
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [DATA_W-1:0]           din,
    input  logic                        pop,
    output logic [DATA_W-1:0]           dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int AW = $clog2(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("gray_word_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Output is forced to zero while empty so an idle port never shows stale data.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gray_frame_packer.sv
// Packs a grayscale pixel stream into 32-bit words with per-frame word addresses
// and drains them to a frame-buffer write port (Wr_valid/Wr_ready: transfer when both high).
module gray_frame_packer
    import gray_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Frame_start,
    input  logic              Valid_in,
    input  logic [7:0]        Grayscale,
    output logic              Wr_valid,
    input  logic              Wr_ready,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [31:0]       Wr_data,
    output logic              Wr_last,
    output logic              Frame_done,
    output logic              Overflow,
    output logic              Busy,
    output logic [1:0]        dbg_state
);

    localparam int NPIX    = IMG_WIDTH * IMG_HEIGHT;
    localparam int NWORDS  = NPIX / PIX_PER_WORD;
    localparam int ENTRY_W = 1 + ADDR_W + WORD_W;
    localparam int PACK_W  = (PIX_PER_WORD - 1) * PIX_W;
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);

    generate
        if ((NPIX % PIX_PER_WORD) != 0) begin : g_bad_geometry
            $error("gray_frame_packer: IMG_WIDTH*IMG_HEIGHT must be divisible by 4");
        end
        if (((NWORDS - 1) >> ADDR_W) != 0) begin : g_bad_addr_w
            $error("gray_frame_packer: ADDR_W too narrow for the frame");
        end
    endgenerate

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          pack_idx;
    logic [1:0]          idx_nxt;
    logic [PACK_W-1:0]   pack_reg;
    logic [PACK_W-1:0]   pack_nxt;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                overflow_q;

    logic [1:0]          eff_idx;
    logic [PACK_W-1:0]   eff_pack;
    logic [ADDR_W-1:0]   eff_addr;
    logic                pix_take;
    logic                word_done;
    logic                word_last;
    logic                frame_end;
    logic                pop_fire;
    logic                drop;

    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_level;

    // Frame_start restarts the frame in the same cycle, so the pixel arriving
    // alongside it is packed against cleared counters.
    assign eff_idx   = Frame_start ? 2'd0 : pack_idx;
    assign eff_pack  = Frame_start ? '0 : pack_reg;
    assign eff_addr  = Frame_start ? '0 : addr_cnt;

    assign pix_take  = Valid_in & (Frame_start | (state == RUN));
    assign word_done = pix_take & (eff_idx == 2'd3);
    assign word_last = (eff_addr == LAST_ADDR);
    assign frame_end = word_done & word_last;
    assign pop_fire  = ~fifo_empty & Wr_ready;
    assign drop      = word_done & fifo_full & ~pop_fire;

    assign push_entry = {word_last, eff_addr, Grayscale, eff_pack};

    always_comb begin
        pack_nxt = eff_pack;
        idx_nxt  = eff_idx;
        addr_nxt = eff_addr;
        if (pix_take) begin
            if (word_done) begin
                pack_nxt = '0;
                idx_nxt  = 2'd0;
                // Advances even when the word is dropped, keeping frame geometry intact.
                addr_nxt = eff_addr + ADDR_W'(1);
            end else begin
                idx_nxt = eff_idx + 2'd1;
                case (eff_idx)
                    2'd0:    pack_nxt[7:0]   = Grayscale;
                    2'd1:    pack_nxt[15:8]  = Grayscale;
                    default: pack_nxt[23:16] = Grayscale;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (Frame_start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (frame_end) state_nxt = DRAIN;
                DRAIN:   if (fifo_empty || ((fifo_level == LVL_W'(1)) && pop_fire)) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pack_idx   <= 2'd0;
            pack_reg   <= '0;
            addr_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pack_idx <= idx_nxt;
            pack_reg <= pack_nxt;
            addr_cnt <= addr_nxt;
            if (Frame_start) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    gray_word_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (Frame_start),
        .push  (word_done),
        .din   (push_entry),
        .pop   (Wr_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign Wr_valid   = ~fifo_empty;
    assign Wr_last    = fifo_dout[ENTRY_W-1];
    assign Wr_addr    = fifo_dout[ENTRY_W-2 -: ADDR_W];
    assign Wr_data    = fifo_dout[WORD_W-1:0];
    assign Frame_done = (state == DONE);
    assign Busy       = (state == RUN) || (state == DRAIN);
    assign Overflow   = overflow_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_gray_frame_packer.sv
// Bench for gray_frame_packer: two instances (4x2 frame / depth 8, 8x4 frame / depth 4)
// checked cycle by cycle against a queue-based reference model.
module tb_gray_frame_packer;

    logic        clk;
    logic        rst_n;
    logic        frame_start [2];
    logic        valid_in    [2];
    logic [7:0]  gray        [2];
    logic        wr_ready    [2];
    logic        wr_valid    [2];
    logic [16:0] wr_addr     [2];
    logic [31:0] wr_data     [2];
    logic        wr_last     [2];
    logic        frame_done  [2];
    logic        overflow    [2];
    logic        busy        [2];
    logic [1:0]  dbg         [2];

    int checks = 0;
    int errors = 0;

    // reference model: expected FIFO contents, frame pixels, phase flags
    logic [49:0] exp_q [$];
    logic [7:0]  fpix  [$];
    int          m_k, m_dep, m_nw;
    bit          m_run, m_drain, m_done, m_ovf;

    // observation records
    logic [16:0] got_addr [$];
    logic [31:0] got_data [$];
    logic        got_last [$];
    int          cyc, last_hs_cyc, done_cnt, done_cyc;
    bit          hold_v;
    logic [49:0] hold_val;

    gray_frame_packer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .FIFO_DEPTH(8), .ADDR_W(17)) dut_a (
        .clk(clk), .rst_n(rst_n), .Frame_start(frame_start[0]), .Valid_in(valid_in[0]),
        .Grayscale(gray[0]), .Wr_valid(wr_valid[0]), .Wr_ready(wr_ready[0]),
        .Wr_addr(wr_addr[0]), .Wr_data(wr_data[0]), .Wr_last(wr_last[0]),
        .Frame_done(frame_done[0]), .Overflow(overflow[0]), .Busy(busy[0]), .dbg_state(dbg[0])
    );

    gray_frame_packer #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .FIFO_DEPTH(4), .ADDR_W(17)) dut_b (
        .clk(clk), .rst_n(rst_n), .Frame_start(frame_start[1]), .Valid_in(valid_in[1]),
        .Grayscale(gray[1]), .Wr_valid(wr_valid[1]), .Wr_ready(wr_ready[1]),
        .Wr_addr(wr_addr[1]), .Wr_data(wr_data[1]), .Wr_last(wr_last[1]),
        .Frame_done(frame_done[1]), .Overflow(overflow[1]), .Busy(busy[1]), .dbg_state(dbg[1])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        exp_q.delete();
        fpix.delete();
        m_k = 0; m_run = 0; m_drain = 0; m_done = 0; m_ovf = 0;
        hold_v = 0;
    endtask

    task automatic set_dut(input int d);
        m_dep = (d == 0) ? 8 : 4;
        m_nw  = (d == 0) ? 2 : 8;
    endtask

    task automatic clear_track();
        got_addr.delete(); got_data.delete(); got_last.delete();
        last_hs_cyc = -10; done_cnt = 0; done_cyc = -10;
    endtask

    // driver: one clock cycle on dut d, with per-cycle checks against the model
    task automatic drive_cycle(input int d, input logic rst, input logic fs, input logic v,
                               input logic [7:0] px, input logic rdy);
        logic [49:0] obs;
        logic [49:0] w;
        logic        exp_v;
        logic        pop;
        rst_n = rst;
        for (int j = 0; j < 2; j++) begin
            frame_start[j] = 1'b0; valid_in[j] = 1'b0; gray[j] = 8'h00; wr_ready[j] = 1'b0;
        end
        frame_start[d] = fs; valid_in[d] = v; gray[d] = px; wr_ready[d] = rdy;
        @(negedge clk);
        obs   = {wr_last[d], wr_addr[d], wr_data[d]};
        exp_v = (exp_q.size() != 0);
        checks++;
        if (wr_valid[d] !== exp_v) begin
            errors++;
            $display("FAIL wr_valid dut%0d cyc%0d got %b exp %b", d, cyc, wr_valid[d], exp_v);
        end
        if (exp_v) begin
            checks++;
            if (obs !== exp_q[0]) begin
                errors++;
                $display("FAIL word dut%0d cyc%0d got %h exp %h", d, cyc, obs, exp_q[0]);
            end
        end
        if (hold_v && wr_valid[d] === 1'b1) begin
            checks++;
            if (obs !== hold_val) begin
                errors++;
                $display("FAIL stable dut%0d cyc%0d got %h exp %h", d, cyc, obs, hold_val);
            end
        end
        checks++;
        if ({frame_done[d], busy[d], overflow[d]} !== {m_done, m_run | m_drain, m_ovf}) begin
            errors++;
            $display("FAIL status dut%0d cyc%0d got done/busy/ovf %b%b%b exp %b%b%b", d, cyc,
                     frame_done[d], busy[d], overflow[d], m_done, m_run | m_drain, m_ovf);
        end
        if (wr_valid[d] === 1'b1 && rdy) begin
            got_addr.push_back(wr_addr[d]);
            got_data.push_back(wr_data[d]);
            got_last.push_back(wr_last[d]);
            last_hs_cyc = cyc;
        end
        if (frame_done[d] === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        hold_v   = (wr_valid[d] === 1'b1) && !rdy && rst && !fs;
        hold_val = obs;

        pop = exp_v && rdy;
        if (!rst) begin
            model_clear();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (fs) begin
                exp_q.delete(); fpix.delete();
                m_ovf = 0; m_k = 0; m_run = 1; m_drain = 0; m_done = 0;
            end else begin
                m_done = 0;
                if (m_drain && exp_q.size() == 0) begin
                    m_drain = 0;
                    m_done  = 1;
                end
            end
            if (v && m_run) begin
                fpix.push_back(px);
                if (m_k % 4 == 3) begin
                    w = {(m_k / 4 == m_nw - 1) ? 1'b1 : 1'b0, 17'(m_k / 4),
                         fpix[m_k], fpix[m_k-1], fpix[m_k-2], fpix[m_k-3]};
                    if (exp_q.size() == m_dep) m_ovf = 1;
                    else exp_q.push_back(w);
                    if (m_k / 4 == m_nw - 1) begin
                        m_run = 0;
                        m_drain = 1;
                    end
                end
                m_k++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        set_dut(d);
        drive_cycle(d, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive_cycle(d, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive_cycle(d, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        set_dut(0);
        drive_cycle(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive_cycle(0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({wr_valid[d], wr_addr[d], wr_data[d], wr_last[d], frame_done[d], overflow[d],
                 busy[d], dbg[d]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got v%b a%h d%h l%b fd%b o%b b%b s%0d exp all 0",
                         d, wr_valid[d], wr_addr[d], wr_data[d], wr_last[d], frame_done[d],
                         overflow[d], busy[d], dbg[d]);
            end
        end
        drive_cycle(0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
    endtask

    task automatic check_small_frame(input string tag);
        checks++;
        if (got_addr.size() != 2) begin
            errors++;
            $display("FAIL %s_count got %0d exp 2", tag, got_addr.size());
        end else begin
            checks++;
            if ({got_data[0], got_addr[0], got_last[0]} !== {32'h04030201, 17'd0, 1'b0}) begin
                errors++;
                $display("FAIL %s_word0 got %h@%0d last%b exp 04030201@0 last0", tag,
                         got_data[0], got_addr[0], got_last[0]);
            end
            checks++;
            if ({got_data[1], got_addr[1], got_last[1]} !== {32'h08070605, 17'd1, 1'b1}) begin
                errors++;
                $display("FAIL %s_word1 got %h@%0d last%b exp 08070605@1 last1", tag,
                         got_data[1], got_addr[1], got_last[1]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL %s_done got cnt %0d at %0d exp 1 at %0d", tag, done_cnt, done_cyc,
                     last_hs_cyc + 1);
        end
        checks++;
        if (busy[0] !== 1'b0 || overflow[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got busy %b ovf %b exp 0 0", tag, busy[0], overflow[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(0);
        clear_track();
        drive_cycle(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 8; i++) drive_cycle(0, 1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 6; i++) drive_cycle(0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check_small_frame("b2b");
    endtask

    task automatic test_gaps();
        do_reset(0);
        clear_track();
        drive_cycle(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(0, 1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
            drive_cycle(0, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
            drive_cycle(0, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
        end
        for (int i = 0; i < 4; i++) drive_cycle(0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check_small_frame("gaps");
    endtask

    task automatic test_overflow();
        do_reset(1);
        clear_track();
        drive_cycle(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 32; i++) drive_cycle(1, 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (overflow[1] !== 1'b1 || got_addr.size() != 0) begin
            errors++;
            $display("FAIL ovf_set got ovf %b xfers %0d exp 1 0", overflow[1], got_addr.size());
        end
        for (int i = 0; i < 10; i++) drive_cycle(1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (got_addr.size() != 4) begin
            errors++;
            $display("FAIL ovf_drain_count got %0d exp 4", got_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_addr[i] !== 17'(i) || got_last[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_addr%0d got %0d last%b exp %0d last0", i, got_addr[i],
                             got_last[i], i);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL ovf_done got cnt %0d at %0d exp 1 at %0d", done_cnt, done_cyc,
                     last_hs_cyc + 1);
        end
    endtask

    task automatic test_toggle_full();
        do_reset(1);
        clear_track();
        drive_cycle(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 32; i++)
            drive_cycle(1, 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)),
                        (i >= 19) && ((i - 19) % 2 == 0));
        for (int i = 0; i < 30; i++) drive_cycle(1, 1'b1, 1'b0, 1'b0, 8'h00, 1'(i % 2));
        checks++;
        if (overflow[1] !== 1'b0 || got_addr.size() != 8 || done_cnt != 1) begin
            errors++;
            $display("FAIL toggle got ovf %b xfers %0d done %0d exp 0 8 1", overflow[1],
                     got_addr.size(), done_cnt);
        end
    endtask

    task automatic test_abort();
        do_reset(1);
        drive_cycle(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 22; i++) drive_cycle(1, 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        checks++;
        if (overflow[1] !== 1'b1 || wr_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got ovf %b valid %b exp 1 1", overflow[1], wr_valid[1]);
        end
        clear_track();
        drive_cycle(1, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);
        checks++;
        if (overflow[1] !== 1'b0 || wr_valid[1] !== 1'b0 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL abort_flush got ovf %b valid %b busy %b exp 0 0 1", overflow[1],
                     wr_valid[1], busy[1]);
        end
        for (int i = 1; i < 32; i++)
            drive_cycle(1, 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)), i > 3);
        for (int i = 0; i < 12; i++) drive_cycle(1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (got_addr.size() == 0) begin
            errors++;
            $display("FAIL abort_first got no transfer exp AA@0");
        end else begin
            checks++;
            if (got_data[0][7:0] !== 8'hAA || got_addr[0] !== 17'd0) begin
                errors++;
                $display("FAIL abort_first got %h@%0d exp ??????AA@0", got_data[0], got_addr[0]);
            end
        end
    endtask

    task automatic test_reset_in_drain();
        do_reset(0);
        clear_track();
        drive_cycle(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) drive_cycle(0, 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        drive_cycle(0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (wr_valid[0] !== 1'b1 || busy[0] !== 1'b1 || dbg[0] !== 2'd2) begin
            errors++;
            $display("FAIL drain_pre got valid %b busy %b state %0d exp 1 1 2", wr_valid[0],
                     busy[0], dbg[0]);
        end
        drive_cycle(0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        checks++;
        if ({wr_valid[0], wr_addr[0], wr_data[0], wr_last[0], frame_done[0], overflow[0],
             busy[0], dbg[0]} !== '0) begin
            errors++;
            $display("FAIL drain_reset got v%b a%h d%h l%b fd%b o%b b%b s%0d exp all 0",
                     wr_valid[0], wr_addr[0], wr_data[0], wr_last[0], frame_done[0],
                     overflow[0], busy[0], dbg[0]);
        end
        for (int i = 0; i < 10; i++) drive_cycle(0, 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        checks++;
        if (dbg[0] !== 2'd0 || got_addr.size() != 0) begin
            errors++;
            $display("FAIL drain_ignore got state %0d xfers %0d exp 0 0", dbg[0], got_addr.size());
        end
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            for (int f = 0; f < 3; f++) begin
                clear_track();
                drive_cycle(d, 1'b1, 1'b1, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                for (int i = 0; i < 400 && (m_run || m_drain || m_done); i++)
                    drive_cycle(d, 1'b1, 1'b0, ($urandom_range(0, 9) < 6),
                                8'($urandom_range(0, 255)), ($urandom_range(0, 9) < 7));
                drive_cycle(d, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
                checks++;
                if (m_run || m_drain || done_cnt != 1) begin
                    errors++;
                    $display("FAIL random dut%0d frame%0d got done %0d exp 1 within budget",
                             d, f, done_cnt);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = 0;
        for (int j = 0; j < 2; j++) begin
            frame_start[j] = 1'b0; valid_in[j] = 1'b0; gray[j] = 8'h00; wr_ready[j] = 1'b0;
        end
        model_clear();
        clear_track();
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_overflow();
        test_toggle_full();
        test_abort();
        test_reset_in_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
